cancid_ctx_mgr: RTL
===================

CANCID_CTX_MGR -- requirements
Module: cancid_ctx_mgr

Interface
REQ-001 Parameter NUM_STREAMS, default 64, number of stream contexts held.
REQ-002 Parameter STATE_W, default 11, width of one matcher state word.
REQ-003 Parameter CNT_W, default 16, width of the match counter.
REQ-004 Derived constant SID_W = clog2(NUM_STREAMS), minimum 1.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 load_state  in  1  start of packet; latch stream_id and enable, restore context.
REQ-008 new_stream_id  in  1  qualifies load_state; force zero state.
REQ-009 stream_id  in  SID_W  stream selector, sampled with load_state.
REQ-010 enable  in  1  matcher enabled for this stream, sampled with load_state.
REQ-011 eop  in  1  end of packet; finalise count, save context.
REQ-012 accept_in  in  1  accept pulse from the matcher engine.
REQ-013 state_from_eng  in  STATE_W  engine's current state, saved at eop.
REQ-014 state_to_eng  out  STATE_W  restored state for the engine.
REQ-015 state_to_eng_vld  out  1  one-cycle strobe; engine loads state_to_eng.
REQ-016 fired  out  1  speculative match flag for the current packet.
REQ-017 count  out  CNT_W  committed packet-match count.
REQ-018 cnt_sat  out  1  sticky; count reached all-ones.
REQ-019 busy  out  1  high while load_state would be ignored.

Function
REQ-020 FSM states IDLE, ACTIVE, SAVE; reset state IDLE.
REQ-021 load_state accepted when busy=0: latch sid and enable, go to ACTIVE, clear fired.
REQ-022 state_to_eng_vld pulses exactly one cycle after an accepted load_state; state_to_eng = 0 if new_stream_id=1 or the valid bit of sid is 0, else the stored context.
REQ-023 accept_in=1 sets fired; accept_in wins over the clear from load_state in the same cycle.
REQ-024 eop in ACTIVE with latched enable=1: count <= count + fired, saturating at 2^CNT_W-1; write state_from_eng to context[sid]; set valid[sid].
REQ-025 eop in ACTIVE with latched enable=0: clear fired; no context write; count unchanged.
REQ-026 eop in IDLE or SAVE is ignored.
REQ-027 cnt_sat sets when count becomes all-ones and holds until reset.
REQ-028 A load_state in the eop cycle is accepted as the next packet, subject to REQ-034/REQ-035.
REQ-029 busy is combinational from FSM state only, with no input feedback.

Reset
REQ-030 On rst_n=0: FSM IDLE; fired, count, cnt_sat, state_to_eng_vld, busy = 0; state_to_eng = 0; all valid bits = 0.
REQ-031 Context storage is not reset; validity comes from the valid bits only.
REQ-032 Reset mid-packet abandons the packet and saves no context.

Configuration
REQ-033 Macro CANCID_CTX_FWD_EN selects the save/restore collision handling.
REQ-034 With CANCID_CTX_FWD_EN: no SAVE state and busy stays 0. A load_state in the eop cycle for the sid being saved returns that cycle's state_from_eng (write-first forwarding).
REQ-035 Without CANCID_CTX_FWD_EN: an enabled eop goes to SAVE for one cycle with busy=1, then IDLE. A load_state while busy=1 is ignored, and the source must hold it.

Structure
REQ-036 The shared package holds the FSM state enum, the SID_W clog2 function and the default parameter values.
REQ-037 One sub-module, cancid_ctx_ram: NUM_STREAMS x STATE_W, one write port, one registered read port, no reset.

Verification
REQ-038 Reset, then load sid=5 with new_stream_id=0 -> state_to_eng=0 (valid=0), state_to_eng_vld one cycle later.
REQ-039 sid=3 enabled, one accept, eop with state_from_eng=0x2A5; reload sid=3 -> count=1, state_to_eng=0x2A5.
REQ-040 sid=7 with enable=0, accept, then eop -> fired=0, count unchanged, context[7] not written.
REQ-041 Preload count=0xFFFE, two matching packets -> count=0xFFFF, cnt_sat=1, count holds on a third match.
REQ-042 With FWD_EN: eop for sid=2 with state 0x011 and load_state sid=2 in the same cycle -> state_to_eng=0x011. Without FWD_EN: busy=1 one cycle, first load ignored.
REQ-043 Assert rst_n mid-packet after an accept -> fired=0, valid bits clear, next load returns 0.

Source files
------------

// File: rtl/cancid_ctx_mgr_pkg.sv
// cancid_ctx_mgr_pkg: FSM states, default sizes and stream-id width helper for the context manager
package cancid_ctx_mgr_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, SAVE} state_e;
  localparam int DEF_NUM_STREAMS = 64;
  localparam int DEF_STATE_W = 11;
  localparam int DEF_CNT_W = 16;
  function automatic int sid_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cancid_ctx_ram.sv
// cancid_ctx_ram: DEPTH x WIDTH context store, one write port, one registered read port (read-old on collision), no reset
module cancid_ctx_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 11,
  parameter int AW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cancid_ctx_mgr.sv
// cancid_ctx_mgr: per-stream matcher context save/restore with speculative fire flag and saturating match count
// Ports: clk, rst_n (async active-low); load_state/new_stream_id/stream_id/enable start a packet;
// eop/accept_in/state_from_eng from the engine; state_to_eng/state_to_eng_vld restore strobe;
// fired, count, cnt_sat, busy status. Macro CANCID_CTX_FWD_EN: write-first forwarding instead of a SAVE cycle.
module cancid_ctx_mgr
  import cancid_ctx_mgr_pkg::*;
#(
  parameter int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter int STATE_W = DEF_STATE_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int SID_W = sid_width(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic               eop,
  input  logic               accept_in,
  input  logic [STATE_W-1:0] state_from_eng,
  output logic [STATE_W-1:0] state_to_eng,
  output logic               state_to_eng_vld,
  output logic               fired,
  output logic [CNT_W-1:0]   count,
  output logic               cnt_sat,
  output logic               busy
);
  state_e state_q;
  logic [SID_W-1:0] sid_q;
  logic en_q, fired_q, sat_q, vld_q, zero_q;
  logic [CNT_W-1:0] count_q, count_inc;
  logic [NUM_STREAMS-1:0] valid_q;
  logic [STATE_W-1:0] ram_rdata;
  logic load_ok, eop_act, eop_en;
`ifdef CANCID_CTX_FWD_EN
  logic fwd_hit, fwd_q;
  logic [STATE_W-1:0] fwd_data_q;
`endif
  always_comb begin
    eop_act = eop && state_q == ACTIVE;
    eop_en = eop_act && en_q;
    count_inc = &count_q ? count_q : count_q + CNT_W'(fired_q);
`ifdef CANCID_CTX_FWD_EN
    load_ok = load_state;
    fwd_hit = eop_en && stream_id == sid_q;
`else
    // an enabled eop owns this cycle; a same-cycle load must be held through SAVE
    load_ok = load_state && state_q != SAVE && !eop_en;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sid_q <= '0;
      en_q <= 1'b0;
      fired_q <= 1'b0;
      count_q <= '0;
      sat_q <= 1'b0;
      vld_q <= 1'b0;
      zero_q <= 1'b1;
      valid_q <= '0;
`ifdef CANCID_CTX_FWD_EN
      fwd_q <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      vld_q <= load_ok;
      fired_q <= accept_in || (fired_q && !load_ok && !eop_act);
      if (load_ok) begin
        sid_q <= stream_id;
        en_q <= enable;
`ifdef CANCID_CTX_FWD_EN
        zero_q <= new_stream_id || !(valid_q[stream_id] || fwd_hit);
        fwd_q <= fwd_hit;
        fwd_data_q <= state_from_eng;
`else
        zero_q <= new_stream_id || !valid_q[stream_id];
`endif
      end
      if (eop_en) begin
        count_q <= count_inc;
        sat_q <= sat_q || &count_inc;
        valid_q[sid_q] <= 1'b1;
      end
`ifdef CANCID_CTX_FWD_EN
      state_q <= load_ok ? ACTIVE : eop_act ? IDLE : state_q;
`else
      state_q <= load_ok ? ACTIVE : eop_en ? SAVE : (eop_act || state_q == SAVE) ? IDLE : state_q;
`endif
    end
  end
  cancid_ctx_ram #(.DEPTH(NUM_STREAMS), .WIDTH(STATE_W), .AW(SID_W)) u_ram (
    .clk(clk),
    .we(eop_en),
    .waddr(sid_q),
    .wdata(state_from_eng),
    .re(load_ok),
    .raddr(stream_id),
    .rdata(ram_rdata)
  );
`ifdef CANCID_CTX_FWD_EN
  assign state_to_eng = zero_q ? '0 : fwd_q ? fwd_data_q : ram_rdata;
  assign busy = 1'b0;
`else
  assign state_to_eng = zero_q ? '0 : ram_rdata;
  assign busy = state_q == SAVE;
`endif
  assign state_to_eng_vld = vld_q;
  assign fired = fired_q;
  assign count = count_q;
  assign cnt_sat = sat_q;
endmodule
